uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_bit_timer.sv | 29 ++
 rtl/uart_tx.sv | 121 ++++++++++++
 tb/tb_uart_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and
// line levels used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int   CLKS_PER_BIT_DEF = 16;
    localparam int   DATA_BITS        = 8;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit clock counter: counts 0..CLKS_PER_BIT-1 while running and flags the
// terminal count so the owning state machine can advance one bit.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_bit_tick
);

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= (r_cnt == LAST_CNT) ? 8'd0 : r_cnt + 8'd1;
        end
    end

    assign o_bit_tick = i_run && (r_cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing with optional even parity, LSB first.
// Line, active and done are registered one cycle behind the state register.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       tx_Clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] i_TX_byte,
    input  logic       i_TX_valid,
    output logic       o_TX_ready,
    output logic       o_TX_serial,
    output logic       o_TX_active,
    output logic       o_TX_done,
    output logic [9:0] o_TX_buffer
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t   r_state;
    tx_state_t   w_next;
    logic [7:0]  r_data;
    logic [9:0]  r_buffer;
    logic [2:0]  r_bit_cnt;
    logic        r_serial;
    logic        r_active;
    logic        r_done;
    logic        w_tick;
    logic        w_accept;
    logic        w_serial_nxt;
    logic        w_active_nxt;
    logic        w_done_nxt;

    // Ready depends on registered state only; reset forces it low.
    assign o_TX_ready = (r_state == IDLE) && enable && !rst;
    assign w_accept   = i_TX_valid && o_TX_ready;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk      (tx_Clk),
        .i_rst      (rst),
        .i_clear    (r_state == IDLE),
        .i_run      (r_state != IDLE),
        .o_bit_tick (w_tick)
    );

    always_ff @(posedge tx_Clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = START;
            START:   if (w_tick) w_next = DATA;
            DATA:    if (w_tick && (r_bit_cnt == LAST_BIT)) w_next = PARITY_EN ? PARITY : STOP;
            PARITY:  if (w_tick) w_next = STOP;
            STOP:    if (w_tick) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_serial_nxt = IDLE_LEVEL;
        w_active_nxt = 1'b1;
        w_done_nxt   = (r_state == STOP) && w_tick;
        case (r_state)
            IDLE:    w_active_nxt = 1'b0;
            START:   w_serial_nxt = START_LEVEL;
            DATA:    w_serial_nxt = r_data[r_bit_cnt];
            PARITY:  w_serial_nxt = even_parity(r_data);
            STOP:    w_serial_nxt = STOP_LEVEL;
            default: w_serial_nxt = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge tx_Clk or posedge rst) begin
        if (rst) begin
            r_serial <= IDLE_LEVEL;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_serial <= w_serial_nxt;
            r_active <= w_active_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // The byte is held unshifted so the parity bit can be formed from it later.
    always_ff @(posedge tx_Clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_buffer  <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_data   <= i_TX_byte;
                r_buffer <= {STOP_LEVEL, i_TX_byte, START_LEVEL};
            end
            if (r_state != DATA) begin
                r_bit_cnt <= '0;
            end else if (w_tick) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    assign o_TX_serial = r_serial;
    assign o_TX_active = r_active;
    assign o_TX_done   = r_done;
    assign o_TX_buffer = r_buffer;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: one instance without and one with parity, driven in
// lockstep and compared cycle by cycle against a bit-slot model of the frame.
module tb_uart_tx;

    localparam int CPB = 16;

    logic       tx_Clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] i_TX_byte;
    logic       i_TX_valid;
    logic       ready0, ser0, act0, done0;
    logic       ready1, ser1, act1, done1;
    logic [9:0] buf0, buf1;

    logic cs [2][0:399];
    logic ca [2][0:399];
    logic cd [2][0:399];
    logic cr [2][0:399];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 tx_Clk = ~tx_Clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_dut0 (
        .tx_Clk(tx_Clk), .rst(rst), .enable(enable),
        .i_TX_byte(i_TX_byte), .i_TX_valid(i_TX_valid),
        .o_TX_ready(ready0), .o_TX_serial(ser0), .o_TX_active(act0),
        .o_TX_done(done0), .o_TX_buffer(buf0)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_dut1 (
        .tx_Clk(tx_Clk), .rst(rst), .enable(enable),
        .i_TX_byte(i_TX_byte), .i_TX_valid(i_TX_valid),
        .o_TX_ready(ready1), .o_TX_serial(ser1), .o_TX_active(act1),
        .o_TX_done(done1), .o_TX_buffer(buf1)
    );

    // Expected line level k edges after the accept edge: slot = (k-1)/CPB,
    // slots are start, d0..d7, [parity], stop, then idle-high.
    function automatic logic exp_line(input logic [7:0] b, input bit par, input int k);
        int idx;
        if (k < 1) return 1'b1;
        idx = (k - 1) / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (par && idx == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic int frame_len(input bit par);
        return (par ? 11 : 10) * CPB;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] b);
        i_TX_byte  = b;
        i_TX_valid = 1'b1;
        @(posedge tx_Clk); #1;
        i_TX_valid = 1'b0;
    endtask

    task automatic run_capture(input int n, input bit noise, input int drop_valid_at, input int en_off_at);
        for (int k = 1; k <= n; k++) begin
            @(posedge tx_Clk); #1;
            cs[0][k] = ser0; ca[0][k] = act0; cd[0][k] = done0; cr[0][k] = ready0;
            cs[1][k] = ser1; ca[1][k] = act1; cd[1][k] = done1; cr[1][k] = ready1;
            if (k == drop_valid_at) i_TX_valid = 1'b0;
            if (k == en_off_at) enable = 1'b0;
            if (noise) begin
                if (k < 150) begin
                    i_TX_valid = 1'($urandom_range(0, 1));
                    i_TX_byte  = 8'($urandom);
                end else begin
                    i_TX_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic check_frame(input int d, input logic [7:0] b, input int n, input bit en);
        int   len, es, ea, ed, er, nact;
        logic [9:0] bv;
        len = frame_len(d == 1);
        es = 0; ea = 0; ed = 0; er = 0; nact = 0;
        for (int k = 1; k <= n; k++) begin
            if (cs[d][k] !== exp_line(b, d == 1, k)) es++;
            if (ca[d][k] !== ((k >= 1) && (k <= len))) ea++;
            if (ca[d][k] === 1'b1) nact++;
            if (cd[d][k] !== (k == len)) ed++;
            if (cr[d][k] !== (en && (k >= len))) er++;
        end
        bv = (d == 1) ? buf1 : buf0;
        chk($sformatf("d%0d_%02h_serial_errs", d, b), es, 0);
        chk($sformatf("d%0d_%02h_active_errs", d, b), ea, 0);
        chk($sformatf("d%0d_%02h_done_errs", d, b), ed, 0);
        chk($sformatf("d%0d_%02h_ready_errs", d, b), er, 0);
        chk($sformatf("d%0d_%02h_frame_len", d, b), nact, len);
        chk($sformatf("d%0d_%02h_buffer", d, b), 32'(bv), 32'({1'b1, b, 1'b0}));
    endtask

    task automatic check_b2b(input int d, input logic [7:0] b1, input logic [7:0] b2, input int n);
        int   len, es, ea, nd, nrdy;
        logic el;
        len = frame_len(d == 1);
        es = 0; ea = 0; nd = 0; nrdy = 0;
        for (int k = 1; k <= n; k++) begin
            el = (k <= len + 1) ? exp_line(b1, d == 1, k) : exp_line(b2, d == 1, k - (len + 1));
            if (cs[d][k] !== el) es++;
            if (ca[d][k] !== (((k >= 1) && (k <= len)) || ((k >= len + 2) && (k <= 2 * len + 1)))) ea++;
            if (cd[d][k] === 1'b1) begin
                if (k != len && k != 2 * len + 1) nd += 100;
                nd++;
            end
            if (k <= 2 * len && cr[d][k] === 1'b1) nrdy++;
        end
        chk($sformatf("d%0d_b2b_serial_errs", d), es, 0);
        chk($sformatf("d%0d_b2b_active_errs", d), ea, 0);
        chk($sformatf("d%0d_b2b_done_pulses", d), nd, 2);
        chk($sformatf("d%0d_b2b_ready_cycles", d), nrdy, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         g;

        // Reset hold and release
        rst = 1'b1; enable = 1'b1; i_TX_valid = 1'b0; i_TX_byte = 8'h00;
        repeat (3) @(posedge tx_Clk);
        #1;
        chk("rst_serial0", 32'(ser0), 1);   chk("rst_serial1", 32'(ser1), 1);
        chk("rst_active0", 32'(act0), 0);   chk("rst_active1", 32'(act1), 0);
        chk("rst_done0",   32'(done0), 0);  chk("rst_done1",   32'(done1), 0);
        chk("rst_buffer0", 32'(buf0), 0);   chk("rst_buffer1", 32'(buf1), 0);
        chk("rst_ready0",  32'(ready0), 0); chk("rst_ready1",  32'(ready1), 0);
        rst = 1'b0;
        @(posedge tx_Clk); #1;
        chk("post_rst_serial", 32'(ser0), 1);
        chk("post_rst_ready0", 32'(ready0), 1);
        chk("post_rst_ready1", 32'(ready1), 1);
        chk("post_rst_done",   32'(done0), 0);

        // Directed 0x55
        accept(8'h55);
        run_capture(180, 1'b0, 0, 0);
        check_frame(0, 8'h55, 180, 1'b1);
        check_frame(1, 8'h55, 180, 1'b1);
        chk("d0_55_done_at_160", 32'(cd[0][160]), 1);

        // Parity slot checks
        accept(8'h07);
        run_capture(180, 1'b0, 0, 0);
        check_frame(1, 8'h07, 180, 1'b1);
        chk("par_07_slot9", 32'(cs[1][9 * CPB + 8]), 1);
        accept(8'h03);
        run_capture(180, 1'b0, 0, 0);
        check_frame(1, 8'h03, 180, 1'b1);
        chk("par_03_slot9", 32'(cs[1][9 * CPB + 8]), 0);

        // Random bytes with valid/byte noise while busy
        for (int t = 0; t < 6; t++) begin
            b = 8'($urandom);
            g = int'($urandom_range(0, 3));
            repeat (g) begin @(posedge tx_Clk); #1; end
            accept(b);
            run_capture(180, 1'b1, 0, 0);
            check_frame(0, b, 180, 1'b1);
            check_frame(1, b, 180, 1'b1);
        end

        // Back-to-back with valid held high
        i_TX_byte = 8'hA5; i_TX_valid = 1'b1;
        @(posedge tx_Clk); #1;
        i_TX_byte = 8'h3C;
        run_capture(360, 1'b0, 200, 0);
        check_b2b(0, 8'hA5, 8'h3C, 360);
        check_b2b(1, 8'hA5, 8'h3C, 360);

        // Enable dropped mid-frame with valid held
        i_TX_byte = 8'hC3; i_TX_valid = 1'b1;
        @(posedge tx_Clk); #1;
        run_capture(180, 1'b0, 0, 40);
        check_frame(0, 8'hC3, 180, 1'b0);
        check_frame(1, 8'hC3, 180, 1'b0);
        enable = 1'b1;
        #1;
        chk("en_back_ready0", 32'(ready0), 1);
        @(posedge tx_Clk); #1;
        i_TX_valid = 1'b0;
        run_capture(180, 1'b0, 0, 0);
        check_frame(0, 8'hC3, 180, 1'b1);

        // Reset in the middle of a 0x00 frame
        accept(8'h00);
        run_capture(50, 1'b0, 0, 0);
        chk("pre_rst_line_low", 32'(ser0), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_serial0", 32'(ser0), 1); chk("async_rst_active0", 32'(act0), 0);
        chk("async_rst_serial1", 32'(ser1), 1); chk("async_rst_active1", 32'(act1), 0);
        g = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge tx_Clk); #1;
            if (done0 !== 1'b0 || done1 !== 1'b0 || ready0 !== 1'b0) g++;
        end
        chk("rst_hold_quiet", g, 0);
        rst = 1'b0;
        @(posedge tx_Clk); #1;
        chk("rst2_ready0", 32'(ready0), 1);
        chk("rst2_done0",  32'(done0), 0);
        b = 8'($urandom);
        accept(b);
        run_capture(180, 1'b0, 0, 0);
        check_frame(0, b, 180, 1'b1);
        check_frame(1, b, 180, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
